// File: rtl/bobc_operativo.sv
// bobc_operativo: BOBC polynomial datapath with add/Horner steps and a W-cycle shift-add multiplier
module bobc_operativo #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         lx,
  input  logic [1:0]   m0,
  input  logic [1:0]   m1,
  input  logic [1:0]   m2,
  input  logic         h,
  input  logic         lh,
  input  logic         ls,
  input  logic         done,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] coef_a,
  input  logic [W-1:0] coef_b,
  input  logic [W-1:0] coef_c,
  output logic         pronto,
  output logic [W-1:0] h_out,
  output logic [W-1:0] y,
  output logic         y_valid
);
  localparam logic IDLE = 1'b0;
  localparam logic MUL  = 1'b1;
  localparam int   CW   = $clog2(W + 1);
  logic          state_q, state_d;
  logic [W-1:0]  x_q, x_d, h_q, h_d, s_q, s_d, y_q, y_d;
  logic [W-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          yv_q, yv_d;
  logic [W-1:0]  a_op, b_mul, b_add, sum, step;
  logic          idle;
  always_comb begin
    idle  = state_q == IDLE;
    a_op  = m0 == 2'b00 ? '0 : m0 == 2'b01 ? coef_a : h_q;
    b_mul = m1[1] ? (m1[0] ? W'(1) : coef_b) : x_q;
    b_add = m2 == 2'b00 ? '0 : m2 == 2'b01 ? coef_b : m2 == 2'b10 ? coef_c : x_q;
    sum   = a_op + b_add;
    step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    state_d  = state_q;
    x_d      = idle && lx ? x_in : x_q;
    s_d      = idle && ls ? sum : s_q;
    y_d      = idle && done ? s_q : y_q;
    yv_d     = idle && done;
    h_d      = idle && lh && !h ? sum : h_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (idle && lh && h) begin
      mcand_d  = a_op;
      mplier_d = b_mul;
      acc_d    = '0;
      cnt_d    = CW'(W);
      state_d  = MUL;
    end else if (!idle) begin
      acc_d    = step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      // last step folds straight into H so pronto rises on the same edge
      if (cnt_q == CW'(1)) begin
        h_d     = step;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      h_q      <= '0;
      s_q      <= '0;
      y_q      <= '0;
      yv_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      h_q      <= h_d;
      s_q      <= s_d;
      y_q      <= y_d;
      yv_q     <= yv_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
  assign pronto  = state_q == IDLE;
  assign h_out   = h_q;
  assign y       = y_q;
  assign y_valid = yv_q;
endmodule

// File: tb/tb_bobc_operativo.sv
// tb_bobc_operativo: directed scenario bench for the BOBC datapath
module tb_bobc_operativo;
  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic       lx = 1'b0, h = 1'b0, lh = 1'b0, ls = 1'b0, done = 1'b0;
  logic [1:0] m0 = 2'b00, m1 = 2'b00, m2 = 2'b00;
  logic [7:0] x_in = 8'd0, coef_a = 8'd0, coef_b = 8'd0, coef_c = 8'd0;
  logic       pronto, y_valid;
  logic [7:0] h_out, y;
  int checks = 0;
  int failures = 0;

  bobc_operativo #(.W(8)) dut (
    .ck(ck), .rst(rst), .lx(lx), .m0(m0), .m1(m1), .m2(m2), .h(h), .lh(lh),
    .ls(ls), .done(done), .x_in(x_in), .coef_a(coef_a), .coef_b(coef_b),
    .coef_c(coef_c), .pronto(pronto), .h_out(h_out), .y(y), .y_valid(y_valid)
  );

  always #5 ck = ~ck;

  task automatic cyc;
    @(posedge ck);
    #1;
  endtask

  task automatic idle_cmds;
    lx = 0; lh = 0; ls = 0; done = 0; h = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!pronto && n < 40) begin
      cyc;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 0;
    idle_cmds;
    cyc; cyc;
    checks++; if (pronto !== 1'b1) begin failures++; $display("FAIL reset_pronto got=%b exp=1", pronto); end
    checks++; if (h_out !== 8'd0) begin failures++; $display("FAIL reset_h got=%0d exp=0", h_out); end
    checks++; if (y !== 8'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_yv got=%b exp=0", y_valid); end
    rst = 1;
    cyc;
  endtask

  task automatic test_horner;
    int n;
    coef_a = 2; coef_b = 5; coef_c = 7; x_in = 3;
    lx = 1; cyc; idle_cmds;
    lh = 1; h = 1; m0 = 2'b01; m1 = 2'b00; cyc; idle_cmds;
    checks++; if (pronto !== 1'b0) begin failures++; $display("FAIL horner_busy got=%b exp=0", pronto); end
    wait_idle(n);
    checks++; if (n !== 8) begin failures++; $display("FAIL horner_lat got=%0d exp=8", n); end
    checks++; if (h_out !== 8'd6) begin failures++; $display("FAIL horner_ax got=%0d exp=6", h_out); end
    lh = 1; h = 0; m0 = 2'b10; m2 = 2'b01; cyc; idle_cmds;
    checks++; if (h_out !== 8'd11) begin failures++; $display("FAIL horner_axb got=%0d exp=11", h_out); end
    lh = 1; h = 1; m0 = 2'b10; m1 = 2'b00; cyc; idle_cmds;
    wait_idle(n);
    checks++; if (h_out !== 8'd33) begin failures++; $display("FAIL horner_axbx got=%0d exp=33", h_out); end
    ls = 1; m0 = 2'b10; m2 = 2'b10; cyc; idle_cmds;
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL horner_nopulse got=%b exp=0", y_valid); end
    done = 1; cyc; idle_cmds;
    checks++; if (y !== 8'd40) begin failures++; $display("FAIL horner_y got=%0d exp=40", y); end
    checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL horner_yv got=%b exp=1", y_valid); end
    cyc;
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL horner_yv_drop got=%b exp=0", y_valid); end
    checks++; if (y !== 8'd40) begin failures++; $display("FAIL horner_y_hold got=%0d exp=40", y); end
  endtask

  task automatic test_latency;
    int busy;
    coef_b = 5;
    lh = 1; h = 1; m0 = 2'b10; m1 = 2'b10; cyc; idle_cmds;
    busy = 0;
    while (!pronto && busy < 40) begin
      busy++;
      checks++; if (h_out !== 8'd33) begin failures++; $display("FAIL lat_h_hold cyc=%0d got=%0d exp=33", busy, h_out); end
      cyc;
    end
    checks++; if (busy !== 8) begin failures++; $display("FAIL lat_cycles got=%0d exp=8", busy); end
    checks++; if (h_out !== 8'd165) begin failures++; $display("FAIL lat_product got=%0d exp=165", h_out); end
  endtask

  task automatic test_overflow;
    int n;
    coef_a = 16; x_in = 16;
    lx = 1; cyc; idle_cmds;
    lh = 1; h = 1; m0 = 2'b01; m1 = 2'b00; cyc; idle_cmds;
    wait_idle(n);
    checks++; if (h_out !== 8'd0) begin failures++; $display("FAIL ovf_mul got=%0d exp=0", h_out); end
    coef_c = 250;
    lh = 1; h = 0; m0 = 2'b00; m2 = 2'b10; cyc; idle_cmds;
    checks++; if (h_out !== 8'd250) begin failures++; $display("FAIL ovf_load got=%0d exp=250", h_out); end
    coef_b = 10;
    lh = 1; h = 0; m0 = 2'b10; m2 = 2'b01; cyc; idle_cmds;
    checks++; if (h_out !== 8'd4) begin failures++; $display("FAIL ovf_add got=%0d exp=4", h_out); end
  endtask

  task automatic test_lockout;
    int n;
    coef_b = 3;
    lh = 1; h = 1; m0 = 2'b10; m1 = 2'b10; cyc; idle_cmds;
    x_in = 99; lx = 1; ls = 1; done = 1; m0 = 2'b10; m2 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cyc;
      checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL lock_yv cyc=%0d got=%b exp=0", i, y_valid); end
      checks++; if (y !== 8'd40) begin failures++; $display("FAIL lock_y cyc=%0d got=%0d exp=40", i, y); end
    end
    idle_cmds;
    wait_idle(n);
    checks++; if (h_out !== 8'd12) begin failures++; $display("FAIL lock_product got=%0d exp=12", h_out); end
    lh = 1; h = 0; m0 = 2'b00; m2 = 2'b11; cyc; idle_cmds;
    checks++; if (h_out !== 8'd16) begin failures++; $display("FAIL lock_x got=%0d exp=16", h_out); end
    done = 1; cyc; idle_cmds;
    checks++; if (y !== 8'd40) begin failures++; $display("FAIL lock_s got=%0d exp=40", y); end
  endtask

  task automatic test_reset_mid;
    coef_a = 2;
    lh = 1; h = 1; m0 = 2'b01; m1 = 2'b00; cyc; idle_cmds;
    cyc; cyc; cyc;
    checks++; if (pronto !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", pronto); end
    rst = 0;
    #1;
    checks++; if (pronto !== 1'b1) begin failures++; $display("FAIL rmid_pronto got=%b exp=1", pronto); end
    checks++; if (h_out !== 8'd0) begin failures++; $display("FAIL rmid_h got=%0d exp=0", h_out); end
    checks++; if (y !== 8'd0) begin failures++; $display("FAIL rmid_y got=%0d exp=0", y); end
    cyc;
    rst = 1;
    for (int i = 0; i < 10; i++) cyc;
    checks++; if (h_out !== 8'd0) begin failures++; $display("FAIL rmid_aborted got=%0d exp=0", h_out); end
    lh = 1; h = 0; m0 = 2'b01; m2 = 2'b11; cyc; idle_cmds;
    checks++; if (h_out !== 8'd2) begin failures++; $display("FAIL rmid_add got=%0d exp=2", h_out); end
  endtask

  task automatic test_simul;
    coef_a = 2; x_in = 3;
    lx = 1; cyc; idle_cmds;
    x_in = 5; lx = 1; lh = 1; h = 0; m0 = 2'b01; m2 = 2'b11; cyc; idle_cmds;
    checks++; if (h_out !== 8'd5) begin failures++; $display("FAIL simul_oldx got=%0d exp=5", h_out); end
    lh = 1; h = 0; m0 = 2'b01; m2 = 2'b11; cyc; idle_cmds;
    checks++; if (h_out !== 8'd7) begin failures++; $display("FAIL simul_newx got=%0d exp=7", h_out); end
  endtask

  task automatic test_combo;
    coef_a = 2; coef_b = 5; coef_c = 7;
    ls = 1; m0 = 2'b01; m2 = 2'b10; cyc; idle_cmds;
    ls = 1; lh = 1; h = 0; done = 1; m0 = 2'b10; m2 = 2'b01; cyc; idle_cmds;
    checks++; if (y !== 8'd9) begin failures++; $display("FAIL combo_old_s got=%0d exp=9", y); end
    checks++; if (h_out !== 8'd12) begin failures++; $display("FAIL combo_h got=%0d exp=12", h_out); end
    done = 1; cyc;
    checks++; if (y !== 8'd12) begin failures++; $display("FAIL combo_s got=%0d exp=12", y); end
    for (int i = 0; i < 2; i++) begin
      cyc;
      checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL held_done cyc=%0d got=%b exp=1", i, y_valid); end
    end
    idle_cmds; cyc;
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL held_release got=%b exp=0", y_valid); end
  endtask

  initial begin
    test_reset;
    test_horner;
    test_latency;
    test_overflow;
    test_lockout;
    test_reset_mid;
    test_simul;
    test_combo;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
